relu_frame_sender: RTL and testbench
====================================

Name: relu_frame_sender

Overview:
- Transmitting end of the layer-input handshake that Layer 2 receives on (ready/received, 4-phase).
- Collects ReLU node results one per cycle from the Layer 1 datapath and saturates each to the Layer 2 input width.
- Stores them in one of two ping-pong frame banks.
- Presents a completed bank as a flat bus and holds it stable until the consumer has acknowledged and released.

Parameters:
- NODES, 128, number of ReLU nodes per frame.
- INDEX_WIDTH, 7, width of node index; must satisfy 2^INDEX_WIDTH >= NODES.
- ACC_WIDTH, 16, width of signed pre-activation input value.
- VALUE_WIDTH, 8, width of unsigned output node value (the Layer 2 input bit width).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- nodeValid  in  1  node write strobe.
- nodeIndex  in  INDEX_WIDTH  node address of the write.
- nodeValue  in  ACC_WIDTH  signed pre-activation value.
- frameLast  in  1  qualifies the current write as the last of its frame.
- acceptReady  out  1  fill bank is free; writes are accepted this cycle.
- indexError  out  1  sticky flag: a write arrived with an out-of-range index.
- outputsReady  out  1  frame on the bus is valid (to Layer 2 inputsReady).
- outputsRecieved  in  1  consumer acknowledge (from Layer 2 inputsRecieved).
- layer2Output  out  NODES*VALUE_WIDTH  frame bus; node i sits at bits [i*VALUE_WIDTH +: VALUE_WIDTH].

Behaviour:
- Reset (reset=0, async):
  - outputsReady=0, indexError=0.
  - Both banks all-zero, both full flags 0, fillPtr=0, sendPtr=0.
  - Send FSM in S_IDLE, so acceptReady=1 and layer2Output=0.
  - Reset mid-handshake drops outputsReady immediately; the frame is discarded.
- Write acceptance:
  - acceptReady = ~full[fillPtr], combinational.
  - A write is accepted at a rising edge when nodeValid=1 and acceptReady=1.
  - When nodeValid=1 and acceptReady=0, the write is ignored. The producer must hold or retry.
- Saturating ReLU on an accepted write, result stored to bank[fillPtr][nodeIndex]:
  - nodeValue < 0 gives 0.
  - nodeValue > 2^VALUE_WIDTH-1 gives 2^VALUE_WIDTH-1.
  - Otherwise the low VALUE_WIDTH bits.
- Out-of-range index (nodeIndex >= NODES) on an accepted write:
  - No bank write; indexError set to 1.
  - indexError is cleared only by reset.
  - frameLast on that write is still honoured.
- Node order: unwritten nodes keep 0, and repeated writes to an index overwrite.
- Frame completion, on an accepted write with frameLast=1:
  - full[fillPtr]<=1 and fillPtr toggles at the same edge.
  - If the other bank is still full, acceptReady falls in the next cycle.
- Send FSM:
  - layer2Output = bank[sendPtr] at all times, combinational mux.
  - S_IDLE: if full[sendPtr], go to S_READY and set outputsReady<=1.
  - S_READY: data held stable. When outputsRecieved=1, set outputsReady<=0 and go to S_RELEASE.
  - S_RELEASE: outputsReady=0 and data still held. When outputsRecieved=0, clear bank[sendPtr] to zero, set full[sendPtr]<=0, toggle sendPtr, and go to S_IDLE.
- Latency:
  - The frameLast edge is N; outputsReady rises at edge N+1 when the send FSM is idle on that bank.
  - The release edge is R; the next full bank is presented with outputsReady at edge R+1.
- Stray acknowledge: outputsRecieved=1 while in S_IDLE is ignored. A new frame waits in S_READY until outputsRecieved is seen high again.
- Simultaneous events:
  - A release in the same cycle as a frameLast write into the other bank is legal; both take effect.
  - A release of bank k while fillPtr==k makes acceptReady rise in the next cycle.
- Bank clearing: clearing on release guarantees that every bank handed to the fill side starts all-zero.

Test Plan (NODES=4, ACC_WIDTH=16, VALUE_WIDTH=8):
1. Reset:
   - Pulse reset low -> outputsReady=0, acceptReady=1, indexError=0, layer2Output=32'h0.
2. Saturating frame and hold:
   - Stimulus: writes idx0=5, idx1=-3, idx2=300, idx3=255 with frameLast, outputsRecieved held 0 for 10 cycles.
   - Response: outputsReady=1 one edge after the last write; layer2Output=32'hFFFF0005, stable for all 10 cycles.
3. Handshake completion:
   - Set outputsRecieved=1 -> outputsReady=0 next edge, bus still 32'hFFFF0005.
   - Drop outputsRecieved -> next edge bus=32'h0 and the bank is free.
4. Ping-pong stall:
   - Stimulus: frame A pending unacknowledged; write frame B (idx0..3 = 1,2,3,4, last on idx3); then attempt idx0=9.
   - Response: acceptReady=0 after B's last write; the idx0=9 write is ignored.
   - After A's handshake completes: outputsReady=1 one edge later, bus=32'h04030201.
5. Partial frame and index error:
   - Write idx2=7 with frameLast -> bus=32'h00070000.
   - Write idx5=1 -> indexError=1, no bank change.
6. Reset during handshake:
   - Assert reset in S_READY -> outputsReady=0 immediately.
   - After release, acceptReady=1 and layer2Output=0; a subsequent frame works normally.

Source files
------------

// File: rtl/relu_frame_sender.sv
// Ping-pong frame buffer that saturates ReLU node results and hands completed
// frames to the next layer over a 4-phase ready/received handshake.
module relu_frame_sender #(
    parameter int NODES       = 128,
    parameter int INDEX_WIDTH = 7,
    parameter int ACC_WIDTH   = 16,
    parameter int VALUE_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         nodeValid,
    input  logic [INDEX_WIDTH-1:0]       nodeIndex,
    input  logic [ACC_WIDTH-1:0]         nodeValue,
    input  logic                         frameLast,
    output logic                         acceptReady,
    output logic                         indexError,
    output logic                         outputsReady,
    input  logic                         outputsRecieved,
    output logic [NODES*VALUE_WIDTH-1:0] layer2Output
);

    localparam int FRAME_W = NODES * VALUE_WIDTH;
    localparam logic [INDEX_WIDTH:0] NODES_L = NODES[INDEX_WIDTH:0];

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READY   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Negative clamps to zero; anything above the output range clamps to all-ones.
    function automatic logic [VALUE_WIDTH-1:0] sat_relu(input logic [ACC_WIDTH-1:0] v);
        logic [VALUE_WIDTH-1:0] res;
        if (v[ACC_WIDTH-1]) begin
            res = {VALUE_WIDTH{1'b0}};
        end else if (|v[ACC_WIDTH-2:VALUE_WIDTH]) begin
            res = {VALUE_WIDTH{1'b1}};
        end else begin
            res = v[VALUE_WIDTH-1:0];
        end
        return res;
    endfunction

    logic [FRAME_W-1:0]     r_bank [2];
    logic [1:0]             r_full;
    logic                   r_fill_ptr;
    logic                   r_send_ptr;
    logic                   r_index_error;
    logic                   r_outputs_ready;
    state_t                 r_state;

    logic                   w_accept;
    logic                   w_index_ok;
    logic                   w_bank_wr;
    logic                   w_frame_done;
    logic                   w_release;
    logic [VALUE_WIDTH-1:0] w_sat;

    assign acceptReady  = ~r_full[r_fill_ptr];
    assign w_accept     = nodeValid & acceptReady;
    assign w_index_ok   = ({1'b0, nodeIndex} < NODES_L);
    assign w_bank_wr    = w_accept & w_index_ok;
    assign w_frame_done = w_accept & frameLast;
    assign w_release    = (r_state == S_RELEASE) & ~outputsRecieved;
    assign w_sat        = sat_relu(nodeValue);

    assign layer2Output = r_bank[r_send_ptr];
    assign indexError   = r_index_error;
    assign outputsReady = r_outputs_ready;

    // Bank storage: node writes into the fill bank, wipe of the send bank on release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bank[0] <= {FRAME_W{1'b0}};
            r_bank[1] <= {FRAME_W{1'b0}};
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_release && (r_send_ptr == 1'(b))) begin
                    r_bank[b] <= {FRAME_W{1'b0}};
                end else if (w_bank_wr && (r_fill_ptr == 1'(b))) begin
                    for (int n = 0; n < NODES; n++) begin
                        if (nodeIndex == INDEX_WIDTH'(n)) begin
                            r_bank[b][n*VALUE_WIDTH +: VALUE_WIDTH] <= w_sat;
                        end
                    end
                end
            end
        end
    end

    // Fill side: full flags, fill pointer and the sticky index error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full        <= 2'b00;
            r_fill_ptr    <= 1'b0;
            r_index_error <= 1'b0;
        end else begin
            // A released bank is always full, so it never collides with the fill bank.
            if (w_frame_done) begin
                r_full[r_fill_ptr] <= 1'b1;
                r_fill_ptr         <= ~r_fill_ptr;
            end
            if (w_release) begin
                r_full[r_send_ptr] <= 1'b0;
            end
            if (w_accept && !w_index_ok) begin
                r_index_error <= 1'b1;
            end
        end
    end

    // Send FSM: present, wait for acknowledge, wait for release, then free the bank.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_outputs_ready <= 1'b0;
            r_send_ptr      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_full[r_send_ptr]) begin
                        r_state         <= S_READY;
                        r_outputs_ready <= 1'b1;
                    end
                end
                S_READY: begin
                    if (outputsRecieved) begin
                        r_state         <= S_RELEASE;
                        r_outputs_ready <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    if (!outputsRecieved) begin
                        r_state    <= S_IDLE;
                        r_send_ptr <= ~r_send_ptr;
                    end
                end
                default: begin
                    r_state         <= S_IDLE;
                    r_outputs_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relu_frame_sender.sv
// Directed bench for relu_frame_sender (NODES=4): frames are queued as expected
// bus values and a monitor checks each presented frame and that it stays stable.
module tb_relu_frame_sender;

    logic        clk;
    logic        reset;
    logic        nodeValid;
    logic [2:0]  nodeIndex;
    logic [15:0] nodeValue;
    logic        frameLast;
    logic        acceptReady;
    logic        indexError;
    logic        outputsReady;
    logic        outputsRecieved;
    logic [31:0] layer2Output;

    int          n_checks;
    int          n_fail;
    logic [31:0] sb_q [$];
    logic [31:0] cur_exp;
    logic        prev_ready;

    relu_frame_sender #(
        .NODES(4), .INDEX_WIDTH(3), .ACC_WIDTH(16), .VALUE_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .nodeValid(nodeValid), .nodeIndex(nodeIndex),
        .nodeValue(nodeValue), .frameLast(frameLast), .acceptReady(acceptReady),
        .indexError(indexError), .outputsReady(outputsReady),
        .outputsRecieved(outputsRecieved), .layer2Output(layer2Output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wr(input logic [2:0] idx, input logic [15:0] val, input logic last);
        @(negedge clk);
        nodeValid = 1'b1;
        nodeIndex = idx;
        nodeValue = val;
        frameLast = last;
        @(posedge clk);
        #1;
        nodeValid = 1'b0;
        frameLast = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        outputsRecieved = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        outputsRecieved = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop on each rising outputsReady, then check the bus stays put.
    initial begin
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_ready = 1'b0;
            end else begin
                if (outputsReady && !prev_ready) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_unexpected_frame: got %h, expected no frame", layer2Output);
                    end else begin
                        cur_exp = sb_q.pop_front();
                        chk("sb_frame", layer2Output, cur_exp);
                    end
                end else if (outputsReady) begin
                    chk("sb_stable", layer2Output, cur_exp);
                end
                prev_ready = outputsReady;
            end
        end
    end

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        cur_exp         = 32'h0;
        reset           = 1'b0;
        nodeValid       = 1'b0;
        nodeIndex       = 3'd0;
        nodeValue       = 16'd0;
        frameLast       = 1'b0;
        outputsRecieved = 1'b0;

        // 1. reset state
        #3;
        chk("rst_outputsReady", {31'd0, outputsReady}, 32'd0);
        chk("rst_acceptReady",  {31'd0, acceptReady},  32'd1);
        chk("rst_indexError",   {31'd0, indexError},   32'd0);
        chk("rst_bus",          layer2Output,          32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // 2. saturating frame held for 10 cycles
        sb_q.push_back(32'hFFFF0005);
        wr(3'd0, 16'd5, 1'b0);
        wr(3'd1, 16'hFFFD, 1'b0);
        wr(3'd2, 16'd300, 1'b0);
        wr(3'd3, 16'd255, 1'b1);
        chk("t2_ready_not_yet", {31'd0, outputsReady}, 32'd0);
        @(posedge clk); #1;
        chk("t2_ready_latency", {31'd0, outputsReady}, 32'd1);
        chk("t2_bus",           layer2Output,          32'hFFFF0005);
        repeat (10) @(posedge clk);
        #1;
        chk("t2_held_ready",    {31'd0, outputsReady}, 32'd1);
        chk("t2_held_bus",      layer2Output,          32'hFFFF0005);

        // 3. handshake completion
        @(negedge clk);
        outputsRecieved = 1'b1;
        @(posedge clk); #1;
        chk("t3_ack_ready",  {31'd0, outputsReady}, 32'd0);
        chk("t3_ack_bus",    layer2Output,          32'hFFFF0005);
        @(negedge clk);
        outputsRecieved = 1'b0;
        @(posedge clk); #1;
        chk("t3_rel_bus",    layer2Output,          32'h0);
        chk("t3_rel_accept", {31'd0, acceptReady},  32'd1);

        // 4. ping-pong stall
        sb_q.push_back(32'h44332211);
        wr(3'd0, 16'h0011, 1'b0);
        wr(3'd1, 16'h0022, 1'b0);
        wr(3'd2, 16'h0033, 1'b0);
        wr(3'd3, 16'h0044, 1'b1);
        @(posedge clk); #1;
        chk("t4_a_ready", {31'd0, outputsReady}, 32'd1);
        sb_q.push_back(32'h04030201);
        wr(3'd0, 16'd1, 1'b0);
        wr(3'd1, 16'd2, 1'b0);
        wr(3'd2, 16'd3, 1'b0);
        wr(3'd3, 16'd4, 1'b1);
        chk("t4_stall", {31'd0, acceptReady}, 32'd0);
        wr(3'd0, 16'd9, 1'b0);
        @(negedge clk);
        outputsRecieved = 1'b1;
        @(posedge clk); #1;
        chk("t4_a_ack_ready", {31'd0, outputsReady}, 32'd0);
        chk("t4_a_ack_bus",   layer2Output,          32'h44332211);
        @(negedge clk);
        outputsRecieved = 1'b0;
        @(posedge clk); #1;
        chk("t4_rel_ready",   {31'd0, outputsReady}, 32'd0);
        chk("t4_rel_accept",  {31'd0, acceptReady},  32'd1);
        @(posedge clk); #1;
        chk("t4_b_ready",     {31'd0, outputsReady}, 32'd1);
        chk("t4_b_bus",       layer2Output,          32'h04030201);
        handshake();
        chk("t4_b_cleared",   layer2Output,          32'h0);

        // 5. partial frame and out-of-range index
        sb_q.push_back(32'h00070000);
        wr(3'd2, 16'd7, 1'b1);
        @(posedge clk); #1;
        chk("t5_partial_bus", layer2Output, 32'h00070000);
        chk("t5_err_before",  {31'd0, indexError}, 32'd0);
        wr(3'd5, 16'd1, 1'b0);
        chk("t5_err_set",     {31'd0, indexError}, 32'd1);
        chk("t5_bus_same",    layer2Output, 32'h00070000);
        handshake();
        sb_q.push_back(32'h0A000000);
        wr(3'd3, 16'h000A, 1'b1);
        @(posedge clk); #1;
        chk("t5_no_bank_write", layer2Output, 32'h0A000000);
        chk("t5_err_sticky",    {31'd0, indexError}, 32'd1);

        // 6. reset during handshake
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_rst_ready",  {31'd0, outputsReady}, 32'd0);
        chk("t6_rst_err",    {31'd0, indexError},   32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_accept",     {31'd0, acceptReady},  32'd1);
        chk("t6_bus",        layer2Output,          32'h0);
        sb_q.push_back(32'h00FF0080);
        wr(3'd0, 16'h0080, 1'b0);
        wr(3'd1, 16'h8000, 1'b0);
        wr(3'd2, 16'h0100, 1'b1);
        @(posedge clk); #1;
        chk("t6_ready",      {31'd0, outputsReady}, 32'd1);
        chk("t6_frame_bus",  layer2Output,          32'h00FF0080);
        handshake();
        chk("t6_done_bus",   layer2Output,          32'h0);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
